// File: rtl/dds_phase_generator_pkg.sv
// Shared definitions for the DDS phase generator and the downstream shaping stage.
package dds_phase_generator_pkg;

  localparam int ACC_W_DEF  = 32;
  localparam int ADDR_W_DEF = 9;

  // Run/stop controller states
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    STOP_PEND = 2'd2
  } dds_state_e;

  // Wave-select codes understood by the shaping stage
  typedef enum logic [1:0] {
    SINE   = 2'd0,
    TRI    = 2'd1,
    SQUARE = 2'd2,
    PWM    = 2'd3
  } wave_sel_e;

endpackage

// File: rtl/dds_freq_buffer.sv
// Single-entry pending frequency-word register. Accepts a word when empty and
// hands it over on apply (apply_ok gates when the owner may consume it).
module dds_freq_buffer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         apply_ok,
  output logic         apply,
  output logic [W-1:0] pend_data
);

  logic [W-1:0] pend_q, pend_d;
  logic         full_q, full_d;
  logic         cap;

  assign in_ready  = ~full_q;
  assign cap       = in_valid & ~full_q;
  assign apply     = full_q & apply_ok;
  assign pend_data = pend_q;

  // Capture when empty, release on apply; the two never coincide since apply needs full
  always_comb begin
    pend_d = cap ? in_data : pend_q;
    full_d = full_q;
    if (apply)    full_d = 1'b0;
    else if (cap) full_d = 1'b1;
  end

  // Pending-word state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      full_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      full_q <= full_d;
    end
  end

endmodule

// File: rtl/dds_phase_generator.sv
// DDS phase accumulator with wrap-synchronous frequency update and a run/stop
// controller that always parks the waveform at phase 0.
// Optional: define PHASE_OFFSET_EN to add a phase_offset input added to address.
module dds_phase_generator
  import dds_phase_generator_pkg::*;
#(
  parameter int ACC_W  = ACC_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [ACC_W-1:0]  freq_word,
  input  logic              freq_valid,
  output logic              freq_ready,
`ifdef PHASE_OFFSET_EN
  input  logic [ADDR_W-1:0] phase_offset,
`endif
  output logic [ADDR_W-1:0] address,
  output logic              enable,
  output logic              wrap,
  output logic              busy
);

  dds_state_e        state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  inc_q, inc_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic              enable_q, enable_d;
  logic              wrap_q, wrap_d;
  logic              busy_q, busy_d;

  logic [ACC_W:0]    sum;
  logic              carry;
  logic              apply;
  logic [ACC_W-1:0]  pend_word;

  assign sum   = {1'b0, acc_q} + {1'b0, inc_q};
  // acc is pinned at 0 in IDLE, so carry only matters while generating
  assign carry = sum[ACC_W] & (state_q != IDLE);

  // Pending word goes live immediately when idle, otherwise only at a wrap
  dds_freq_buffer #(.W(ACC_W)) u_freq_buf (
    .clk       (clk),
    .rst       (rst),
    .in_data   (freq_word),
    .in_valid  (freq_valid),
    .in_ready  (freq_ready),
    .apply_ok  ((state_q == IDLE) | carry),
    .apply     (apply),
    .pend_data (pend_word)
  );

  // Next-state, accumulator and registered-output computation
  always_comb begin
    state_d = state_q;
    acc_d   = sum[ACC_W-1:0];
    inc_d   = apply ? pend_word : inc_q;
    case (state_q)
      IDLE: begin
        acc_d = '0;
        if (start && !stop) state_d = RUN;
      end
      RUN: begin
        if (stop) begin
          // With a zero increment a wrap never comes, so stop right away
          if (inc_q == '0) begin
            state_d = IDLE;
            acc_d   = '0;
          end else begin
            state_d = STOP_PEND;
          end
        end
      end
      STOP_PEND: begin
        if (carry) begin
          state_d = IDLE;
          acc_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        acc_d   = '0;
      end
    endcase
    wrap_d   = carry;
    enable_d = (state_d != IDLE);
    busy_d   = (state_d != IDLE);
`ifdef PHASE_OFFSET_EN
    address_d = (state_d == IDLE) ? '0 : acc_d[ACC_W-1 -: ADDR_W] + phase_offset;
`else
    address_d = acc_d[ACC_W-1 -: ADDR_W];
`endif
  end

  // All state and outputs registered together so address/wrap/enable line up
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      inc_q     <= '0;
      address_q <= '0;
      enable_q  <= 1'b0;
      wrap_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      inc_q     <= inc_d;
      address_q <= address_d;
      enable_q  <= enable_d;
      wrap_q    <= wrap_d;
      busy_q    <= busy_d;
    end
  end

  assign address = address_q;
  assign enable  = enable_q;
  assign wrap    = wrap_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_dds_phase_generator.sv
// Self-checking bench for dds_phase_generator: directed scenarios plus random
// traffic, all compared each cycle against a cycle-level reference model.
module tb_dds_phase_generator;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, stop, freq_valid, freq_ready;
  logic [31:0] freq_word;
  logic [8:0]  address;
  logic        enable, wrap, busy;
`ifdef PHASE_OFFSET_EN
  logic [8:0]  phase_offset;
`endif

  dds_phase_generator dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .freq_word  (freq_word),
    .freq_valid (freq_valid),
    .freq_ready (freq_ready),
`ifdef PHASE_OFFSET_EN
    .phase_offset (phase_offset),
`endif
    .address    (address),
    .enable     (enable),
    .wrap       (wrap),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int off      = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: phase as 33-bit arithmetic, run mode as a small integer
  // (0 idle, 1 running, 2 stopping at next wrap)
  logic [31:0] m_acc, m_inc, m_pend;
  bit          m_pf;
  int          m_mode;

  task automatic m_reset();
    m_acc = 0; m_inc = 0; m_pend = 0; m_pf = 0; m_mode = 0;
  endtask

  task automatic step();
    logic [32:0] s;
    bit          c, cap, app;
    logic [31:0] n_acc, n_inc, n_pend;
    bit          n_pf;
    int          n_mode;
    logic [8:0]  e_addr, off9;
    s      = {1'b0, m_acc} + {1'b0, m_inc};
    c      = (m_mode != 0) && s[32];
    cap    = freq_valid && !m_pf;
    app    = m_pf && (m_mode == 0 || c);
    n_inc  = app ? m_pend : m_inc;
    n_pend = cap ? freq_word : m_pend;
    n_pf   = app ? 1'b0 : (cap ? 1'b1 : m_pf);
    n_mode = m_mode;
    n_acc  = s[31:0];
    if (m_mode == 0) begin
      n_acc = 0;
      if (start && !stop) n_mode = 1;
    end else if (m_mode == 1) begin
      if (stop) begin
        if (m_inc == 0) begin n_mode = 0; n_acc = 0; end
        else n_mode = 2;
      end
    end else if (c) begin
      n_mode = 0; n_acc = 0;
    end
`ifdef PHASE_OFFSET_EN
    off9 = phase_offset;
`else
    off9 = 9'd0;
`endif
    e_addr = (n_mode == 0) ? 9'd0 : 9'(n_acc[31:23] + off9);
    @(posedge clk);
    m_acc = n_acc; m_inc = n_inc; m_pend = n_pend; m_pf = n_pf; m_mode = n_mode;
    #1;
    chk("address",    64'(address),    64'(e_addr));
    chk("enable",     64'(enable),     64'(n_mode != 0));
    chk("busy",       64'(busy),       64'(n_mode != 0));
    chk("wrap",       64'(wrap),       64'(c));
    chk("freq_ready", 64'(freq_ready), 64'(!n_pf));
  endtask

  task automatic load(input logic [31:0] w);
    freq_valid = 1'b1; freq_word = w;
    step();
    freq_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_addr"},  64'(address),    64'd0);
    chk({tag, "_en"},    64'(enable),     64'd0);
    chk({tag, "_busy"},  64'(busy),       64'd0);
    chk({tag, "_wrap"},  64'(wrap),       64'd0);
    chk({tag, "_ready"}, 64'(freq_ready), 64'd1);
  endtask

  initial begin
    int  n;
    bit  hit;
    logic [8:0] prev;
`ifdef PHASE_OFFSET_EN
    off = 256;
    phase_offset = 9'd256;
`endif
    rst = 1'b1; start = 0; stop = 0; freq_valid = 0; freq_word = 0;
    m_reset();
    #12;
    check_reset_outputs("rst0");
    @(negedge clk); rst = 1'b0;

    // Basic run: 1 address step per clock, wrap every 512 cycles at address 0
    load(32'h0080_0000);
    step();
    start = 1'b1; step(); start = 1'b0;
    chk("run_first", 64'(address), 64'((0 + off) % 512));
    for (int k = 1; k <= 600; k++) begin
      step();
      chk("run_addr", 64'(address), 64'((k + off) % 512));
      chk("run_wrap", 64'(wrap), 64'(k % 512 == 0));
    end

    // Glitch-free update: captured mid-cycle, applied only at the wrap
    n = 0;
    while (address != 9'((100 + off) % 512) && n < 600) begin step(); n++; end
    chk("reach_100", 64'(n < 600), 64'd1);
    load(32'h0100_0000);
    chk("pend_ready_low", 64'(freq_ready), 64'd0);
    // Second word while pending is full must be refused
    load(32'h0000_0001);
    chk("second_refused", 64'(freq_ready), 64'd0);
    n = 0; hit = 0;
    while (!hit && n < 600) begin
      prev = address;
      step(); n++;
      if (wrap) hit = 1;
      else chk("step1_delta", 64'(9'(address - prev)), 64'd1);
    end
    chk("glitch_wrap_seen", 64'(hit), 64'd1);
    chk("glitch_wrap_addr", 64'(address), 64'(off % 512));
    step();
    chk("step2_a", 64'(address), 64'((2 + off) % 512));
    chk("ready_after_wrap", 64'(freq_ready), 64'd1);
    step();
    chk("step2_b", 64'(address), 64'((4 + off) % 512));

    // Stop at zero: stop at 300, run out to 510, park at 0 on the wrap
    n = 0;
    while (address != 9'((300 + off) % 512) && n < 600) begin step(); n++; end
    chk("reach_300", 64'(n < 600), 64'd1);
    stop = 1'b1; step(); stop = 1'b0;
    n = 0; prev = address;
    while (enable && n < 600) begin prev = address; step(); n++; end
    chk("stop_done",  64'(n < 600), 64'd1);
    chk("stop_last",  64'(prev), 64'((510 + off) % 512));
    chk("stop_addr0", 64'(address), 64'd0);
    chk("stop_wrap",  64'(wrap), 64'd1);
    chk("stop_busy",  64'(busy), 64'd0);
    step();
    chk("stop_idle",  64'(enable), 64'd0);

    // Zero increment: stop in RUN drops to IDLE on the next clock
    load(32'h0); step();
    start = 1'b1; step(); start = 1'b0;
    chk("zinc_run", 64'(enable), 64'd1);
    step();
    stop = 1'b1; step(); stop = 1'b0;
    chk("zinc_stop", 64'(enable), 64'd0);

    // start and stop together in IDLE: stop wins
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    chk("ss_idle", 64'(busy), 64'd0);

    // Random traffic against the model
    for (int i = 0; i < 2000; i++) begin
      start      = ($urandom_range(0, 7) == 0);
      stop       = ($urandom_range(0, 31) == 0);
      freq_valid = ($urandom_range(0, 3) == 0);
      freq_word  = ($urandom_range(0, 15) == 0) ? 32'h0 : ($urandom >> $urandom_range(0, 8));
`ifdef PHASE_OFFSET_EN
      if ($urandom_range(0, 63) == 0) phase_offset = 9'($urandom);
`endif
      step();
    end
    start = 0; stop = 0; freq_valid = 0;
`ifdef PHASE_OFFSET_EN
    phase_offset = 9'd256;
`endif

    // Reset mid-RUN, checked with no clock edge in between
    @(negedge clk); rst = 1'b1; #2; rst = 1'b0; m_reset();
    load(32'h0080_0000); step();
    start = 1'b1; step(); start = 1'b0;
    for (int k = 0; k < 50; k++) step();
    chk("pre_rst_en", 64'(enable), 64'd1);
    load(32'h0100_0000);
    #2; rst = 1'b1; #1;
    check_reset_outputs("rst_mid");
    m_reset();
    @(negedge clk); rst = 1'b0;
    step(); step();
    chk("rst_pend_gone", 64'(freq_ready), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dds_phase_generator.md
Name: dds_phase_generator

Overview:
- DDS phase accumulator directly upstream of the waveform shaping stage.
- Produces the 9-bit phase `address` and the `enable` that the shaping stage consumes.
- Frequency-word updates are double-buffered and applied only at phase wrap, so the output has no phase discontinuity mid-cycle.
- A run/stop state machine always stops the waveform at phase 0.

Parameters:
- ACC_W, 32, phase accumulator width in bits.
- ADDR_W, 9, output phase address width; the address is the top ADDR_W bits of the accumulator.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  request to begin generation (level sampled each cycle).
- stop  input  1  request to end generation at the next phase wrap.
- freq_word  input  ACC_W  phase increment per clock.
- freq_valid  input  1  freq_word is presented.
- freq_ready  output  1  pending buffer is empty; transfer occurs when freq_valid & freq_ready.
- address  output  ADDR_W  phase address, registered.
- enable  output  1  high while generating; drives the shaping stage's enable.
- wrap  output  1  one-cycle pulse on accumulator carry-out.
- busy  output  1  high in RUN or STOP_PEND.

Behaviour:
- Reset (async, rst=1): acc=0, inc=0, pending buffer empty, state IDLE. Outputs: address=0, enable=0, wrap=0, busy=0, freq_ready=1.
- freq_ready = ~pend_full (combinational). On valid&ready, freq_word is latched into pend and pend_full is set.
- Pending apply:
  - IDLE: inc<=pend on the cycle after capture; pend_full clears.
  - RUN / STOP_PEND: inc<=pend only on a wrap cycle; the new inc is used from the following add.
- States:
  - IDLE: acc held at 0.
    - start & ~stop -> RUN; acc stays 0, so the first address is 0.
    - start & stop together -> remain IDLE (stop wins).
  - RUN: acc<=acc+inc each cycle, modulo 2^ACC_W.
    - stop -> STOP_PEND.
    - start is ignored.
  - STOP_PEND: accumulation continues.
    - On the wrap cycle -> IDLE, with acc forced to 0 (not the residual).
    - start is ignored.
- Zero increment: stop in RUN with inc==0 -> IDLE immediately, since a wrap would never occur.
- Wrap: carry-out of the ACC_W add. wrap is registered and is high in the same cycle address shows the post-wrap value.
- address = acc[ACC_W-1 -: ADDR_W]; latency 1 clock from the acc update.
- enable and busy are registered (state != IDLE). enable deasserts in the same cycle address returns to 0.
- Simultaneous capture and wrap: a word captured in the wrap cycle is not applied until the next wrap. The word already pending is applied in that cycle.
- Reset mid-operation: immediate return to reset values. The pending word is discarded.

Optional Feature:
- Macro: PHASE_OFFSET_EN.
- Defined:
  - Adds input port phase_offset[ADDR_W-1:0].
  - address = (acc top bits + phase_offset) mod 2^ADDR_W, still registered, latency 1.
  - In IDLE, address = 0 regardless of phase_offset.
- Undefined: port absent; address is the raw accumulator top bits.

Decomposition:
- Shared package:
  - State encoding: IDLE=2'd0, RUN=2'd1, STOP_PEND=2'd2.
  - ACC_W/ADDR_W defaults.
  - Wave-select codes shared with the shaping stage: SINE=0, TRI=1, SQUARE=2, PWM=3.
- One natural sub-module: dds_freq_buffer, the single-entry pending register with valid/ready and apply strobe.
- Accumulator and FSM stay in the top module.

Test Plan:
- Reset checks: assert rst mid-RUN with inc=0x0080_0000 -> address=0, enable=0, busy=0, freq_ready=1 immediately, with no clock edge required.
- Basic run: load 0x0080_0000 in IDLE, then start -> address 0,1,2,… one step per clk; wrap pulses every 512 cycles, coincident with address=0.
- Glitch-free update: in RUN at address 100 with inc=0x0080_0000, load 0x0100_0000 -> steps of 1 continue until wrap; after wrap, steps of 2 (0,2,4…); freq_ready stays low until the wrap.
- Stop at zero: stop at address 300 -> enable stays high through address 511, then address=0 and enable=0 on the wrap cycle; state is IDLE.
- Boundary cases:
  - stop in RUN with inc=0 -> IDLE next cycle.
  - start & stop together in IDLE -> stays IDLE.
  - Second freq_valid while pend_full -> not accepted; freq_ready=0.
- PHASE_OFFSET_EN: phase_offset=256, inc=0x0080_0000 -> address sequence 256,257,…,511,0,…
